// File: rtl/matrix_max_scan.sv
// Streams N_ELEM unsigned 32-bit elements and tracks the largest value and its arrival index,
// using an external registered comparator (A/B out, L/G/E flags back one cycle later).
module matrix_max_scan #(
  parameter int unsigned N_ELEM = 16,
  parameter int unsigned IDX_W  = ($clog2(N_ELEM) > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             elem_valid,
  input  logic [31:0]      elem_data,
  output logic             elem_ready,
  output logic [31:0]      cmp_a,
  output logic [31:0]      cmp_b,
  input  logic             cmp_l,
  input  logic             cmp_g,
  input  logic             cmp_e,
  output logic [31:0]      max_val,
  output logic [IDX_W-1:0] max_idx,
  output logic             busy,
  output logic             done
);

  // One extra bit so count can reach N_ELEM without wrapping.
  localparam int unsigned CntW = IDX_W + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N_ELEM);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StCmp,
    StEval,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      max_val_q, max_val_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic [31:0]      cand_q, cand_d;
  logic [IDX_W-1:0] cand_idx_q, cand_idx_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             take_cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      max_val_q  <= '0;
      max_idx_q  <= '0;
      cand_q     <= '0;
      cand_idx_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      max_val_q  <= max_val_d;
      max_idx_q  <= max_idx_d;
      cand_q     <= cand_d;
      cand_idx_q <= cand_idx_d;
      count_q    <= count_d;
    end
  end

  // Only a clean "greater" result replaces the maximum; ties keep the earliest index.
  assign take_cand = cmp_g & ~cmp_l & ~cmp_e;

  always_comb begin
    state_d    = state_q;
    max_val_d  = max_val_q;
    max_idx_d  = max_idx_q;
    cand_d     = cand_q;
    cand_idx_d = cand_idx_q;
    count_d    = count_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (elem_valid) begin
          max_val_d = elem_data;
          max_idx_d = '0;
          count_d   = CntOne;
          state_d   = (N_ELEM == 1) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (elem_valid) begin
          cand_d     = elem_data;
          cand_idx_d = count_q[IDX_W-1:0];
          count_d    = count_q + CntOne;
          state_d    = StCmp;
        end
      end
      StCmp: begin
        state_d = StEval;
      end
      StEval: begin
        if (take_cand) begin
          max_val_d = cand_q;
          max_idx_d = cand_idx_q;
        end
        state_d = (count_q == CntLast) ? StDone : StIssue;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    elem_ready = (state_q == StLoad) || (state_q == StIssue);
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
  end

  assign cmp_a   = cand_q;
  assign cmp_b   = max_val_q;
  assign max_val = max_val_q;
  assign max_idx = max_idx_q;

endmodule

// File: tb/tb_matrix_max_scan.sv
// Directed bench for matrix_max_scan: table of 16-element scans plus hand-written sequences
// for mid-scan reset, result hold, and a single-element build.
module tb_matrix_max_scan;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        elem_valid;
  logic [31:0] elem_data;
  logic        elem_ready;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic        cmp_l;
  logic        cmp_g;
  logic        cmp_e;
  logic [31:0] max_val;
  logic [3:0]  max_idx;
  logic        busy;
  logic        done;

  logic        start1;
  logic        elem_valid1;
  logic [31:0] elem_data1;
  logic        elem_ready1;
  logic [31:0] cmp_a1;
  logic [31:0] cmp_b1;
  logic        cmp_l1;
  logic        cmp_g1;
  logic        cmp_e1;
  logic [31:0] max_val1;
  logic [0:0]  max_idx1;
  logic        busy1;
  logic        done1;

  int n_cmp;
  int n_fail;

  logic [31:0] vec [16];

  matrix_max_scan #(.N_ELEM(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .elem_valid (elem_valid),
    .elem_data  (elem_data),
    .elem_ready (elem_ready),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .cmp_l      (cmp_l),
    .cmp_g      (cmp_g),
    .cmp_e      (cmp_e),
    .max_val    (max_val),
    .max_idx    (max_idx),
    .busy       (busy),
    .done       (done)
  );

  matrix_max_scan #(.N_ELEM(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .elem_valid (elem_valid1),
    .elem_data  (elem_data1),
    .elem_ready (elem_ready1),
    .cmp_a      (cmp_a1),
    .cmp_b      (cmp_b1),
    .cmp_l      (cmp_l1),
    .cmp_g      (cmp_g1),
    .cmp_e      (cmp_e1),
    .max_val    (max_val1),
    .max_idx    (max_idx1),
    .busy       (busy1),
    .done       (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered comparator models, one-cycle flag latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_l  <= 1'b0;
      cmp_g  <= 1'b0;
      cmp_e  <= 1'b0;
      cmp_l1 <= 1'b0;
      cmp_g1 <= 1'b0;
      cmp_e1 <= 1'b0;
    end else begin
      cmp_l  <= cmp_a < cmp_b;
      cmp_g  <= cmp_a > cmp_b;
      cmp_e  <= cmp_a == cmp_b;
      cmp_l1 <= cmp_a1 < cmp_b1;
      cmp_g1 <= cmp_a1 > cmp_b1;
      cmp_e1 <= cmp_a1 == cmp_b1;
    end
  end

  typedef struct {
    bit          ramp;
    logic [31:0] fill;
    int          ia;
    logic [31:0] va;
    int          ib;
    logic [31:0] vb;
    bit          gaps;
    bit          hold_start;
    logic [31:0] exp_val;
    int          exp_idx;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic build(input vec_t r);
    for (int i = 0; i < 16; i++) begin
      vec[i] = r.ramp ? 32'(i * 3) : r.fill;
    end
    vec[r.ia] = r.va;
    vec[r.ib] = r.vb;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_elem_ready"}, 32'(elem_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_max_val"}, max_val, 32'd0);
    check({tag, "_max_idx"}, 32'(max_idx), 32'd0);
    check({tag, "_cmp_a"}, cmp_a, 32'd0);
    check({tag, "_cmp_b"}, cmp_b, 32'd0);
  endtask

  // Called at posedge+1. Cycle numbering: start is sampled at the end of cycle 0.
  task automatic scan(input bit gaps, input bit hold_start, input int abort_at,
                      output int done_cyc, output int n_acc, output int ready_bad);
    int idx;
    int hold;
    int gap_left;
    bit acc;
    idx       = 0;
    hold      = 0;
    gap_left  = 0;
    done_cyc  = -1;
    ready_bad = 0;
    n_acc     = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (hold > 0) begin
        if (elem_ready) ready_bad++;
        hold--;
      end
      elem_valid = (idx < 16) && (gap_left == 0);
      elem_data  = vec[idx % 16];
      if (gap_left > 0) gap_left--;
      acc = elem_valid && elem_ready;
      @(posedge clk);
      if (acc) begin
        if (idx > 0) hold = 2;
        idx++;
        if (gaps) gap_left = $urandom_range(0, 5);
        if (idx == abort_at) begin
          rst_n      = 1'b0;
          elem_valid = 1'b0;
          start      = 1'b0;
          n_acc      = idx;
          #1;
          return;
        end
      end
      #1;
    end
    n_acc      = idx;
    elem_valid = 1'b0;
    if (done_cyc > 0) begin
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_after_done", 32'(busy), 32'd0);
    end
    start = 1'b0;
  endtask

  initial begin
    int dc;
    int na;
    int rb;
    n_cmp       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    elem_valid  = 1'b0;
    elem_data   = '0;
    start1      = 1'b0;
    elem_valid1 = 1'b0;
    elem_data1  = '0;

    //          ramp fill          ia va            ib vb            gap hold exp_val      idx
    tbl[0] = '{1'b1, 32'h0,        5, 32'hFFFF_0000, 5, 32'hFFFF_0000, 1'b0, 1'b0, 32'hFFFF_0000, 5};
    tbl[1] = '{1'b0, 32'h7,        2, 32'h80,        9, 32'h80,        1'b0, 1'b0, 32'h80,        2};
    tbl[2] = '{1'b0, 32'h0,        0, 32'h0,         0, 32'h0,         1'b0, 1'b0, 32'h0,         0};
    tbl[3] = '{1'b0, 32'h0,        0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF, 0};
    tbl[4] = '{1'b1, 32'h0,        0, 32'h0,         0, 32'h0,         1'b0, 1'b0, 32'd45,        15};
    tbl[5] = '{1'b0, 32'h1,        3, 32'h7FFF_FFFF, 12, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 12};
    tbl[6] = '{1'b1, 32'h0,        5, 32'hFFFF_0000, 5, 32'hFFFF_0000, 1'b1, 1'b0, 32'hFFFF_0000, 5};
    tbl[7] = '{1'b0, 32'h10,       7, 32'h11,        8, 32'h11,        1'b0, 1'b1, 32'h11,        7};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_n1_busy", 32'(busy1), 32'd0);
    rst_n = 1'b1;

    // Valid data in IDLE must be ignored.
    elem_valid = 1'b1;
    elem_data  = 32'd99;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready", 32'(elem_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_max_val", max_val, 32'd0);
    elem_valid = 1'b0;

    for (int r = 0; r < 8; r++) begin
      build(tbl[r]);
      scan(tbl[r].gaps, tbl[r].hold_start, -1, dc, na, rb);
      check($sformatf("v%0d_max_val", r), max_val, tbl[r].exp_val);
      check($sformatf("v%0d_max_idx", r), 32'(max_idx), 32'(tbl[r].exp_idx));
      check($sformatf("v%0d_cmp_b", r), cmp_b, tbl[r].exp_val);
      check($sformatf("v%0d_done_seen", r), 32'(dc > 0), 32'd1);
      check($sformatf("v%0d_accepted", r), 32'(na), 32'd16);
      check($sformatf("v%0d_ready_low_cmp_eval", r), 32'(rb), 32'd0);
      if (!tbl[r].gaps) check($sformatf("v%0d_done_cycle", r), 32'(dc), 32'd47);
    end

    // Reset after the ninth accepted element aborts the scan.
    build(tbl[0]);
    scan(1'b0, 1'b0, 9, dc, na, rb);
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    scan(1'b0, 1'b0, -1, dc, na, rb);
    check("rescan_max_val", max_val, 32'hFFFF_0000);
    check("rescan_max_idx", 32'(max_idx), 32'd5);
    check("rescan_done_cycle", 32'(dc), 32'd47);

    // Result holds through LOAD until the first element is accepted.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("hold_max_val", max_val, 32'hFFFF_0000);
    check("hold_max_idx", 32'(max_idx), 32'd5);
    check("load_ready", 32'(elem_ready), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    elem_valid = 1'b1;
    elem_data  = 32'd3;
    @(posedge clk);
    #1;
    elem_valid = 1'b0;
    check("load_max_val", max_val, 32'd3);
    check("load_max_idx", 32'(max_idx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-element build: LOAD goes straight to DONE.
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    check("n1_load_ready", 32'(elem_ready1), 32'd1);
    elem_valid1 = 1'b1;
    elem_data1  = 32'h1234;
    @(posedge clk);
    #1;
    elem_valid1 = 1'b0;
    check("n1_done", 32'(done1), 32'd1);
    check("n1_max_val", max_val1, 32'h1234);
    check("n1_max_idx", 32'(max_idx1), 32'd0);
    @(posedge clk);
    #1;
    check("n1_done_one_cycle", 32'(done1), 32'd0);
    check("n1_idle", 32'(busy1), 32'd0);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1      = 1'b0;
    elem_valid1 = 1'b1;
    elem_data1  = 32'h5;
    @(posedge clk);
    #1;
    elem_valid1 = 1'b0;
    check("n1_second_max_val", max_val1, 32'h5);
    check("n1_second_done", 32'(done1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
